// File: rtl/clk_div_ctrl.sv
// Run-time programmable even clock divider; ratio changes and stops only land on
// divided-period boundaries so clk_div never produces a runt high or low phase.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             clk_en,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy
);

  typedef enum logic [1:0] {OFF, RUN, PEND} state_t;

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] half_m1;
  logic             accept;
  logic             legal;
  logic             take;
  logic             last_cnt;

  assign half_m1   = {1'b0, cur_div[CNT_W-1:1]} - ONE;
  assign last_cnt  = (cnt == half_m1);
  assign cfg_ready = (state != PEND);
  assign busy      = (state != OFF);
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = !cfg_div[0] && (cfg_div >= TWO);
  assign take      = accept && legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      clk_div  <= 1'b0;
      clk_en   <= 1'b0;
      cfg_err  <= 1'b0;
      cnt      <= '0;
      cur_div  <= DEF;
      pend_div <= DEF;
    end else begin
      clk_en  <= 1'b0;
      cfg_err <= accept && !legal;
      case (state)
        OFF: begin
          // A ratio written in the same cycle as en already governs the first period.
          if (take) cur_div <= cfg_div;
          if (en) begin
            clk_div <= 1'b1;
            clk_en  <= 1'b1;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        default: begin
          if (clk_div) begin
            if (last_cnt) begin
              clk_div <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
            if (take) begin
              pend_div <= cfg_div;
              state    <= PEND;
            end
          end else if (last_cnt) begin
            // Period boundary: swap in any pending ratio, then restart or stop.
            cnt <= '0;
            if (state == PEND) cur_div <= pend_div;
            if (en) begin
              clk_div <= 1'b1;
              clk_en  <= 1'b1;
              state   <= take ? PEND : RUN;
              if (take) pend_div <= cfg_div;
            end else begin
              state <= OFF;
              if (take) cur_div <= cfg_div;
            end
          end else begin
            cnt <= cnt + ONE;
            if (take) begin
              pend_div <= cfg_div;
              state    <= PEND;
            end
          end
        end
      endcase
    end
  end

endmodule
